command_tag_response_router: RTL and testbench

Return path for the command arbitration stage. Allocates a CAPI command tag for each granted command and records which requester owns it. When the PSL response for that tag arrives, the block routes it back to the owning requester's response port and recycles the tag. It sits between the arbitrated command/response interface and the NUM_REQUESTS compute-unit command buffers.

---
 rtl/command_tag_response_router_pkg.sv | 24 ++
 rtl/command_tag_response_router_tag_free_list.sv | 68 ++++++
 rtl/command_tag_response_router.sv | 159 +++++++++++++++
 tb/tb_command_tag_response_router.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_tag_response_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : command_tag_response_router_pkg
// Description : Shared types and PSL response codes for the tag return path.
// Revision    : 1.0 - initial release
// ============================================================================
package command_tag_response_router_pkg;

    localparam int DEFAULT_TAG_WIDTH = 8;

    localparam logic [7:0] c_resp_done    = 8'h00;
    localparam logic [7:0] c_resp_aerror  = 8'h01;
    localparam logic [7:0] c_resp_derror  = 8'h03;
    localparam logic [7:0] c_resp_flushed = 8'h06;
    localparam logic [7:0] c_resp_paged   = 8'h0A;

    typedef struct packed {
        logic                         valid;
        logic [DEFAULT_TAG_WIDTH-1:0] tag;
        logic [7:0]                   response;
    } ResponseBufferLine;

endpackage
`default_nettype wire

// File: rtl/command_tag_response_router_tag_free_list.sv
`default_nettype none
// ============================================================================
// Module      : command_tag_response_router_tag_free_list
// Description : Circular FIFO of free tags; pointers reset, storage does not.
// Revision    : 1.0 - initial release
// ============================================================================
module command_tag_response_router_tag_free_list
    import command_tag_response_router_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = DEFAULT_TAG_WIDTH
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[tail_q] <= push_data;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/command_tag_response_router.sv
`default_nettype none
// ============================================================================
// Module      : command_tag_response_router
// Description : Allocates CAPI command tags, tracks owners, routes responses.
// Revision    : 1.0 - initial release
// ============================================================================
module command_tag_response_router
    import command_tag_response_router_pkg::*;
#(
    parameter int NUM_REQUESTS = 4,
    parameter int NUM_TAGS     = 64,
    parameter int TAG_WIDTH    = DEFAULT_TAG_WIDTH,
    parameter int ID_WIDTH     = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1
) (
    input  logic                       clock,
    input  logic                       rstn,
    input  logic                       enabled_in,
    input  logic                       cmd_issue_valid,
    input  logic [ID_WIDTH-1:0]        cmd_issue_id,
    output logic [TAG_WIDTH-1:0]       cmd_tag_out,
    output logic                       tag_available,
    input  ResponseBufferLine          response_in,
    output ResponseBufferLine          response_out [NUM_REQUESTS],
    output logic                       response_error,
    output logic [$clog2(NUM_TAGS):0]  outstanding_count,
    output logic                       init_done
);

    localparam int IDX_W = $clog2(NUM_TAGS);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [0:0] c_st_init  = 1'b0;
    localparam logic [0:0] c_st_ready = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
    logic                enabled_q, enabled_d;
    logic [NUM_TAGS-1:0] owner_valid_q, owner_valid_d;
    logic [ID_WIDTH-1:0] owner_id_q [NUM_TAGS];
    logic [ID_WIDTH-1:0] owner_id_d [NUM_TAGS];
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic                resp_err_q, resp_err_d;
    ResponseBufferLine   resp_out_q [NUM_REQUESTS];
    ResponseBufferLine   resp_out_d [NUM_REQUESTS];

    logic [TAG_WIDTH-1:0] fl_head;
    logic [TAG_WIDTH-1:0] fl_push_data;
    logic [CNT_W-1:0]     fl_count;
    logic                 fl_push;
    logic                 issue;
    logic                 resp_hit;
    logic [IDX_W-1:0]     resp_idx;
    logic [IDX_W-1:0]     head_idx;

    assign resp_idx = response_in.tag[IDX_W-1:0];
    assign head_idx = fl_head[IDX_W-1:0];
    // Owner lookup uses the pre-edge table, so a same-cycle issue of this tag is not yet visible.
    assign resp_hit = response_in.valid
                    && (int'(response_in.tag) < NUM_TAGS)
                    && owner_valid_q[resp_idx];

    assign tag_available = (state_q == c_st_ready) && enabled_q && (fl_count != '0);
    assign issue         = cmd_issue_valid && tag_available;

    command_tag_response_router_tag_free_list #(
        .DEPTH (NUM_TAGS),
        .WIDTH (TAG_WIDTH)
    ) u_free_list (
        .clock     (clock),
        .rstn      (rstn),
        .push      (fl_push),
        .push_data (fl_push_data),
        .pop       (issue),
        .head_data (fl_head),
        .count     (fl_count)
    );

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        enabled_d     = enabled_in;
        owner_valid_d = owner_valid_q;
        owner_id_d    = owner_id_q;
        outstanding_d = outstanding_q;
        resp_err_d    = response_in.valid && !resp_hit;
        fl_push       = 1'b0;
        fl_push_data  = '0;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            resp_out_d[i] = '0;
        end

        if (state_q == c_st_init) begin
            fl_push      = 1'b1;
            fl_push_data = TAG_WIDTH'(init_cnt_q);
            init_cnt_d   = init_cnt_q + IDX_W'(1);
            if (init_cnt_q == IDX_W'(NUM_TAGS - 1)) begin
                state_d = c_st_ready;
            end
        end

        // A hit tag is owned, hence never the free-list head being issued this cycle.
        if (resp_hit) begin
            owner_valid_d[resp_idx]          = 1'b0;
            fl_push                          = 1'b1;
            fl_push_data                     = response_in.tag;
            resp_out_d[owner_id_q[resp_idx]] = response_in;
        end

        if (issue) begin
            owner_valid_d[head_idx] = 1'b1;
            owner_id_d[head_idx]    = cmd_issue_id;
        end

        case ({issue, resp_hit})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q       <= c_st_init;
            init_cnt_q    <= '0;
            enabled_q     <= 1'b0;
            owner_valid_q <= '0;
            outstanding_q <= '0;
            resp_err_q    <= 1'b0;
            for (int i = 0; i < NUM_REQUESTS; i++) begin
                resp_out_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            enabled_q     <= enabled_d;
            owner_valid_q <= owner_valid_d;
            outstanding_q <= outstanding_d;
            resp_err_q    <= resp_err_d;
            for (int i = 0; i < NUM_REQUESTS; i++) begin
                resp_out_q[i] <= resp_out_d[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        owner_id_q <= owner_id_d;
    end

    for (genvar g = 0; g < NUM_REQUESTS; g++) begin : g_resp_out
        assign response_out[g] = resp_out_q[g];
    end

    assign cmd_tag_out       = (state_q == c_st_ready) ? fl_head : '0;
    assign response_error    = resp_err_q;
    assign outstanding_count = outstanding_q;
    assign init_done         = (state_q == c_st_ready);

endmodule
`default_nettype wire

// File: tb/tb_command_tag_response_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_command_tag_response_router
// Description : Directed bench with a queue-based reference model and per-cycle compare.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_command_tag_response_router;
    import command_tag_response_router_pkg::*;

    localparam int NR = 4;
    localparam int NT = 64;

    logic              clock = 1'b0;
    logic              rstn = 1'b0;
    logic              enabled_in = 1'b0;
    logic              cmd_issue_valid = 1'b0;
    logic [1:0]        cmd_issue_id = 2'd0;
    logic [7:0]        cmd_tag_out;
    logic              tag_available;
    ResponseBufferLine response_in;
    ResponseBufferLine response_out [NR];
    logic              response_error;
    logic [6:0]        outstanding_count;
    logic              init_done;

    always #5 clock = ~clock;

    command_tag_response_router #(
        .NUM_REQUESTS (NR),
        .NUM_TAGS     (NT),
        .TAG_WIDTH    (8)
    ) dut (
        .clock             (clock),
        .rstn              (rstn),
        .enabled_in        (enabled_in),
        .cmd_issue_valid   (cmd_issue_valid),
        .cmd_issue_id      (cmd_issue_id),
        .cmd_tag_out       (cmd_tag_out),
        .tag_available     (tag_available),
        .response_in       (response_in),
        .response_out      (response_out),
        .response_error    (response_error),
        .outstanding_count (outstanding_count),
        .init_done         (init_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit                m_live = 1'b0;
    bit                m_ready = 1'b0;
    int                m_init = 0;
    bit                m_en = 1'b0;
    int                m_free [$];
    int                m_owner [NT];
    bit                m_ownv [NT];
    int                m_outst = 0;
    bit                m_err = 1'b0;
    ResponseBufferLine m_out [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: free tags as a queue, owners as an array.
    task automatic model_step();
        bit hit;
        bit iss;
        int t;
        int head;
        if (!rstn) begin
            m_live  = 1'b1;
            m_ready = 1'b0;
            m_init  = 0;
            m_en    = 1'b0;
            m_free.delete();
            for (int i = 0; i < NT; i++) m_ownv[i] = 1'b0;
            m_outst = 0;
            m_err   = 1'b0;
            for (int i = 0; i < NR; i++) m_out[i] = '0;
            return;
        end
        if (!m_live) return;
        iss = cmd_issue_valid && m_ready && m_en && (m_free.size() != 0);
        t   = int'(response_in.tag);
        hit = response_in.valid && (t < NT) && m_ownv[t];
        for (int i = 0; i < NR; i++) m_out[i] = '0;
        m_err = response_in.valid && !hit;
        if (hit) begin
            m_out[m_owner[t]] = response_in;
            m_ownv[t] = 1'b0;
        end
        if (iss) begin
            head = m_free.pop_front();
            m_owner[head] = int'(cmd_issue_id);
            m_ownv[head]  = 1'b1;
        end
        if (hit) m_free.push_back(t);
        m_outst = m_outst + int'(iss) - int'(hit);
        if (!m_ready) begin
            m_free.push_back(m_init);
            m_init++;
            if (m_init == NT) m_ready = 1'b1;
        end
        m_en = enabled_in;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (m_live) begin
            check("tag_available", 32'(tag_available), 32'(m_ready && m_en && (m_free.size() != 0)));
            check("init_done", 32'(init_done), 32'(m_ready));
            check("outstanding_count", 32'(outstanding_count), 32'(m_outst));
            check("response_error", 32'(response_error), 32'(m_err));
            if (!m_ready)
                check("cmd_tag_out_init", 32'(cmd_tag_out), 32'd0);
            else if (m_free.size() != 0)
                check("cmd_tag_out", 32'(cmd_tag_out), 32'(m_free[0]));
            for (int i = 0; i < NR; i++)
                check($sformatf("response_out[%0d]", i), 32'(response_out[i]), 32'(m_out[i]));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue_cmd(input logic [1:0] id);
        cmd_issue_valid = 1'b1;
        cmd_issue_id    = id;
        tick(1);
        cmd_issue_valid = 1'b0;
    endtask

    task automatic set_resp(input int tag, input logic [7:0] code);
        response_in.valid    = 1'b1;
        response_in.tag      = 8'(tag);
        response_in.response = code;
    endtask

    task automatic respond(input int tag, input logic [7:0] code);
        set_resp(tag, code);
        tick(1);
        response_in = '0;
    endtask

    function automatic logic [7:0] code_of(input int k);
        case (k % 5)
            0:       return c_resp_done;
            1:       return c_resp_aerror;
            2:       return c_resp_derror;
            3:       return c_resp_flushed;
            default: return c_resp_paged;
        endcase
    endfunction

    int first_tag;
    int held_tag;

    initial begin
        response_in = '0;
        enabled_in  = 1'b1;
        rstn        = 1'b0;
        tick(3);
        rstn = 1'b1;

        tick(63);
        check("init_done_at_63", 32'(init_done), 32'd0);
        check("tag_avail_at_63", 32'(tag_available), 32'd0);
        tick(1);
        check("init_done_at_64", 32'(init_done), 32'd1);
        check("tag_avail_at_64", 32'(tag_available), 32'd1);
        check("first_tag", 32'(cmd_tag_out), 32'd0);
        check("outstanding_idle", 32'(outstanding_count), 32'd0);

        issue_cmd(2'd2);
        issue_cmd(2'd1);
        check("outstanding_after_2", 32'(outstanding_count), 32'd2);
        check("next_tag", 32'(cmd_tag_out), 32'd2);
        respond(1, c_resp_done);
        check("route_port1_valid", 32'(response_out[1].valid), 32'd1);
        check("route_port1_tag", 32'(response_out[1].tag), 32'd1);
        check("route_port2_quiet", 32'(response_out[2].valid), 32'd0);
        check("outstanding_after_resp", 32'(outstanding_count), 32'd1);

        respond(70, c_resp_done);
        check("err_out_of_range", 32'(response_error), 32'd1);
        check("err_no_route", 32'(response_out[2].valid), 32'd0);
        respond(10, c_resp_aerror);
        check("err_unowned", 32'(response_error), 32'd1);
        check("err_count_kept", 32'(outstanding_count), 32'd1);
        tick(1);
        check("err_pulse_ends", 32'(response_error), 32'd0);

        for (int i = 0; i < 63; i++) issue_cmd(2'(i % 4));
        check("outstanding_full", 32'(outstanding_count), 32'd64);
        check("tag_avail_full", 32'(tag_available), 32'd0);
        cmd_issue_valid = 1'b1;
        cmd_issue_id    = 2'd3;
        tick(1);
        check("ignored_issue", 32'(outstanding_count), 32'd64);
        set_resp(5, c_resp_paged);
        tick(1);
        response_in     = '0;
        cmd_issue_valid = 1'b0;
        check("freed_tag_avail", 32'(tag_available), 32'd1);
        check("freed_tag_head", 32'(cmd_tag_out), 32'd5);
        check("freed_tag_count", 32'(outstanding_count), 32'd63);
        check("tag5_owner_id3", 32'(response_out[3].valid), 32'd1);

        for (int t = 0; t < NT; t++) if (m_ownv[t]) respond(t, code_of(t));
        check("drained", 32'(outstanding_count), 32'd0);

        first_tag = m_free[0];
        issue_cmd(2'd0);
        issue_cmd(2'd1);
        issue_cmd(2'd2);
        cmd_issue_valid = 1'b1;
        cmd_issue_id    = 2'd3;
        set_resp(first_tag, c_resp_derror);
        tick(1);
        cmd_issue_valid = 1'b0;
        response_in     = '0;
        check("simul_count_steady", 32'(outstanding_count), 32'd3);
        check("simul_route_port0", 32'(response_out[0].valid), 32'd1);

        issue_cmd(2'd1);
        check("four_outstanding", 32'(outstanding_count), 32'd4);
        enabled_in = 1'b0;
        tick(1);
        check("disabled_no_tag", 32'(tag_available), 32'd0);
        cmd_issue_valid = 1'b1;
        for (int t = 0; t < NT; t++) if (m_ownv[t]) respond(t, code_of(t + 1));
        cmd_issue_valid = 1'b0;
        check("disabled_drained", 32'(outstanding_count), 32'd0);

        enabled_in = 1'b1;
        tick(2);
        issue_cmd(2'd0);
        issue_cmd(2'd1);
        held_tag = -1;
        for (int t = 0; t < NT; t++) if (m_ownv[t] && held_tag < 0) held_tag = t;
        set_resp(held_tag, c_resp_done);
        rstn = 1'b0;
        tick(1);
        response_in = '0;
        check("rst_outstanding", 32'(outstanding_count), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_no_route", 32'({response_out[0].valid, response_out[1].valid,
                                   response_out[2].valid, response_out[3].valid}), 32'd0);
        check("rst_cmd_tag", 32'(cmd_tag_out), 32'd0);
        rstn = 1'b1;
        tick(63);
        check("reinit_at_63", 32'(init_done), 32'd0);
        tick(1);
        check("reinit_at_64", 32'(init_done), 32'd1);
        respond(held_tag, c_resp_done);
        check("stale_tag_error", 32'(response_error), 32'd1);
        check("stale_tag_no_route", 32'({response_out[0].valid, response_out[1].valid,
                                         response_out[2].valid, response_out[3].valid}), 32'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
